// File: rtl/aes_key_schedule.sv
// AES-128 key-expansion engine with an 11-entry round-key store and a
// registered read port that serves encrypt keys directly and decrypt
// middle-round keys in equivalent-inverse-cipher (InvMixColumns) form.

// Job type shared with the round pipeline that consumes these keys.
package aes_ks_pkg;
    typedef enum logic [1:0] {
        ENCRYPT = 2'd0,
        DECRYPT = 2'd1,
        INVALID = 2'd2
    } job_t;
endpackage

// InvMixColumns on a full 128-bit state, byte 0 at [127:120], columns of
// four consecutive bytes. Purely combinational.
module inv_mixColumns (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0;
        logic [7:0] w_a1;
        logic [7:0] w_a2;
        logic [7:0] w_a3;

        assign w_a0 = i_state[127 - 32*c -: 8];
        assign w_a1 = i_state[119 - 32*c -: 8];
        assign w_a2 = i_state[111 - 32*c -: 8];
        assign w_a3 = i_state[103 - 32*c -: 8];

        assign o_state[127 - 32*c -: 8] = mul14(w_a0) ^ mul11(w_a1) ^ mul13(w_a2) ^ mul9(w_a3);
        assign o_state[119 - 32*c -: 8] = mul9(w_a0)  ^ mul14(w_a1) ^ mul11(w_a2) ^ mul13(w_a3);
        assign o_state[111 - 32*c -: 8] = mul13(w_a0) ^ mul9(w_a1)  ^ mul14(w_a2) ^ mul11(w_a3);
        assign o_state[103 - 32*c -: 8] = mul11(w_a0) ^ mul13(w_a1) ^ mul9(w_a2)  ^ mul14(w_a3);
    end

endmodule

// Key schedule top: accepts a cipher key, expands one round key per cycle,
// then holds the schedule stable for the read port until the next key.
module aes_key_schedule
    import aes_ks_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    input  job_t         rd_type,
    output logic [127:0] rd_key
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] READY  = 2'd2;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    // Forward AES S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [1:0]   r_state;
    logic [3:0]   r_ctr;
    logic [127:0] r_rk [0:NR];
    logic         r_keysValid;
    logic         r_started;
    logic [127:0] r_rdKey;

    logic         w_accept;
    logic [3:0]   w_prevIdx;
    logic [127:0] w_prevKey;
    logic [31:0]  w_w3;
    logic [31:0]  w_temp;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [127:0] w_nextKey;

    logic         w_rdIdxOk;
    logic [3:0]   w_rdIdxSafe;
    logic [127:0] w_rdRaw;
    logic [127:0] w_rdInv;
    logic [127:0] w_rdNext;

    // key_ready is held low until one clock has passed after reset release.
    assign key_ready  = r_started && ((r_state == IDLE) || (r_state == READY));
    assign w_accept   = key_valid && key_ready;
    assign keys_valid = r_keysValid;
    assign rd_key     = r_rdKey;

    // One expansion step from the key at r_ctr-1 using Rcon for round r_ctr.
    always_comb begin
        w_prevIdx = (r_ctr == 4'd0) ? 4'd0 : (r_ctr - 4'd1);
        w_prevKey = r_rk[w_prevIdx];
        w_w3      = w_prevKey[31:0];
        w_temp    = subWord({w_w3[23:0], w_w3[31:24]}) ^ {rcon(r_ctr), 24'h000000};
        w_n0      = w_prevKey[127:96] ^ w_temp;
        w_n1      = w_prevKey[95:64] ^ w_n0;
        w_n2      = w_prevKey[63:32] ^ w_n1;
        w_n3      = w_w3 ^ w_n2;
        w_nextKey = {w_n0, w_n1, w_n2, w_n3};
    end

    // FSM, round counter and round-key store; one new round key per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ctr       <= 4'd0;
            r_keysValid <= 1'b0;
            r_started   <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                r_rk[i] <= '0;
            end
        end else begin
            r_started <= 1'b1;
            case (r_state)
                IDLE, READY: begin
                    if (w_accept) begin
                        r_rk[0]     <= key_in;
                        r_ctr       <= 4'd1;
                        r_keysValid <= 1'b0;
                        r_state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    r_rk[r_ctr] <= w_nextKey;
                    if (r_ctr == LAST_IDX) begin
                        r_ctr       <= 4'd0;
                        r_keysValid <= 1'b1;
                        r_state     <= READY;
                    end else begin
                        r_ctr <= r_ctr + 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_rdIdxOk   = (rd_idx <= LAST_IDX);
    assign w_rdIdxSafe = w_rdIdxOk ? rd_idx : 4'd0;
    assign w_rdRaw     = r_rk[w_rdIdxSafe];

    inv_mixColumns u_invMix (
        .i_state (w_rdRaw),
        .o_state (w_rdInv)
    );

    // Select the read-port value; anything not fully valid reads as zero.
    always_comb begin
        w_rdNext = '0;
        if (r_keysValid && w_rdIdxOk) begin
            case (rd_type)
                ENCRYPT: w_rdNext = w_rdRaw;
                DECRYPT: begin
                    if ((rd_idx == 4'd0) || (rd_idx == LAST_IDX)) begin
                        w_rdNext = w_rdRaw;
                    end else begin
                        w_rdNext = w_rdInv;
                    end
                end
                default: w_rdNext = '0;
            endcase
        end
    end

    // Register the read port so rd_key lags its request by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdKey <= '0;
        end else begin
            r_rdKey <= w_rdNext;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: the driver pushes expected values
// tagged with the cycle they are due, and a monitor compares on negedges.
module tb_aes_key_schedule;
    import aes_ks_pkg::*;

    localparam int K_RDKEY  = 0;
    localparam int K_KVALID = 1;
    localparam int K_KREADY = 2;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_J = 128'hdeadbeefcafef00d0123456789abcdef;

    typedef struct {
        int           kind;
        int           due;
        logic [127:0] exp;
        string        name;
    } chk_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic         keys_valid;
    logic [3:0]   rd_idx = 4'd0;
    job_t         rd_type = ENCRYPT;
    logic [127:0] rd_key;

    int           cyc = 0;
    int           checkCount = 0;
    int           passCount = 0;
    chk_t         sbQ[$];
    logic [7:0]   sboxM [256];
    logic [127:0] modelRk [11];
    logic [127:0] oldExp;

    aes_key_schedule #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_type    (rd_type),
        .rd_key     (rd_key)
    );

    // Free-running clock and a cycle counter that tags due times.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // GF(2^8) multiply used to derive the S-box and InvMixColumns from first principles.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Build the S-box as multiplicative inverse followed by the affine map.
    task automatic buildSbox();
        logic [7:0] xb;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxM[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWordM(input logic [31:0] w);
        return {sboxM[w[31:24]], sboxM[w[23:16]], sboxM[w[15:8]], sboxM[w[7:0]]};
    endfunction

    // Word-oriented key expansion into modelRk[0..10].
    task automatic computeModel(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subWordM({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            modelRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [7:0] invCoef(input int d);
        logic [7:0] c;
        case (d)
            0:       c = 8'h0e;
            1:       c = 8'h0b;
            2:       c = 8'h0d;
            default: c = 8'h09;
        endcase
        return c;
    endfunction

    // Matrix-form InvMixColumns over each column.
    function automatic logic [127:0] invMixM(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(invCoef((k - r + 4) % 4), s[127 - 8*(4*c + k) -: 8]);
                end
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] decExp(input int i);
        return ((i == 0) || (i == 10)) ? modelRk[i] : invMixM(modelRk[i]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushCheck(input int kind, input int due, input logic [127:0] exp, input string name);
        chk_t c;
        c.kind = kind;
        c.due  = due;
        c.exp  = exp;
        c.name = name;
        sbQ.push_back(c);
    endtask

    // Compare one scoreboard entry against the live DUT outputs.
    task automatic checkOutput(input chk_t c);
        logic [127:0] act;
        case (c.kind)
            K_RDKEY:  act = rd_key;
            K_KVALID: act = {127'd0, keys_valid};
            default:  act = {127'd0, key_ready};
        endcase
        checkCount++;
        if (c.due < cyc) begin
            $display("[TB] FAIL %s: check missed at cycle %0d (due %0d), got %h, required %h",
                     c.name, cyc, c.due, act, c.exp);
        end else if (act !== c.exp) begin
            $display("[TB] FAIL %s: cycle %0d got %h, required %h", c.name, cyc, act, c.exp);
        end else begin
            passCount++;
        end
    endtask

    // Issue one read request; its result is due one cycle later.
    task automatic applyStimulus(input logic [3:0] idx, input job_t typ, input logic [127:0] exp,
                                 input string name);
        rd_idx  = idx;
        rd_type = typ;
        pushCheck(K_RDKEY, cyc + 1, exp, name);
        tick();
    endtask

    // Present a key for one cycle together with a read sampled at the same edge.
    task automatic loadKey(input logic [127:0] key, input logic [3:0] idx, input job_t typ,
                           input logic [127:0] rdExp, input string name);
        pushCheck(K_KREADY, cyc, 128'd1, "keyReadyBeforeLoad");
        key_in    = key;
        key_valid = 1'b1;
        rd_idx    = idx;
        rd_type   = typ;
        pushCheck(K_RDKEY, cyc + 1, rdExp, name);
        pushCheck(K_KREADY, cyc + 1, 128'd0, "keyReadyDropsOnAccept");
        pushCheck(K_KVALID, cyc + 1, 128'd0, "keysValidLowOnAccept");
        computeModel(key);
        tick();
        key_valid = 1'b0;
    endtask

    // Walk the ten expansion cycles, reading (expect zero) and optionally pulsing a junk key.
    task automatic expandWait(input logic [127:0] junk, input bit pulse);
        for (int j = 0; j < 10; j++) begin
            pushCheck(K_KVALID, cyc, 128'd0, "keysValidLowDuringExpand");
            pushCheck(K_KREADY, cyc, 128'd0, "keyReadyLowDuringExpand");
            key_valid = pulse && ((j == 2) || (j == 5) || (j == 9));
            key_in    = junk;
            applyStimulus(4'(j + 1), (j % 2 == 1) ? DECRYPT : ENCRYPT, 128'd0, "readDuringExpand");
        end
        key_valid = 1'b0;
        pushCheck(K_KVALID, cyc, 128'd1, "keysValidAfterTen");
        pushCheck(K_KREADY, cyc, 128'd1, "keyReadyInReady");
    endtask

    // Back-to-back sweep of all indices, alternating job type each cycle.
    task automatic sweepKeys(input bit startDec, input string tag);
        bit dec;
        for (int i = 0; i < 11; i++) begin
            dec = startDec ^ (i % 2 == 1);
            applyStimulus(4'(i), dec ? DECRYPT : ENCRYPT, dec ? decExp(i) : modelRk[i], tag);
        end
    endtask

    task automatic printSummary();
        $display("%0d/%0d checks passed", passCount, checkCount);
    endtask

    // Monitor: compare every scoreboard entry that has come due.
    always @(negedge clk) begin : monitor
        int qi;
        qi = 0;
        while (qi < sbQ.size()) begin
            if (sbQ[qi].due <= cyc) begin
                checkOutput(sbQ[qi]);
                sbQ.delete(qi);
            end else begin
                qi++;
            end
        end
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #200000;
        checkCount++;
        $display("[TB] FAIL watchdog: got no completion by time limit, required normal finish");
        printSummary();
        $finish;
    end

    // Directed stimulus sequence.
    initial begin
        buildSbox();
        #1 rst_n = 1'b0;
        tick();
        pushCheck(K_KREADY, cyc, 128'd0, "resetKeyReady");
        pushCheck(K_KVALID, cyc, 128'd0, "resetKeysValid");
        pushCheck(K_RDKEY, cyc, 128'd0, "resetRdKey");
        tick();
        rst_n = 1'b1;
        pushCheck(K_KREADY, cyc, 128'd0, "keyReadyBeforeFirstClock");
        tick();
        pushCheck(K_KREADY, cyc, 128'd1, "keyReadyAfterFirstClock");
        pushCheck(K_KVALID, cyc, 128'd0, "keysValidIdle");
        applyStimulus(4'd0, ENCRYPT, 128'd0, "readIdleEmpty");

        loadKey(KEY_A, 4'd0, ENCRYPT, 128'd0, "readAtFirstAccept");
        expandWait(KEY_J, 1'b0);
        applyStimulus(4'd10, ENCRYPT, 128'h13111d7fe3944a17f307a78b4d2b30c5, "keyA_enc10");
        sweepKeys(1'b0, "sweepA_encFirst");
        sweepKeys(1'b1, "sweepA_decFirst");
        applyStimulus(4'd5, INVALID, 128'd0, "invalidType");
        for (int i = 11; i < 16; i++) begin
            applyStimulus(4'(i), (i % 2 == 1) ? DECRYPT : ENCRYPT, 128'd0, "idxOutOfRange");
        end

        oldExp = modelRk[4];
        loadKey(KEY_B, 4'd4, ENCRYPT, oldExp, "readAtReloadEdge");
        expandWait(KEY_J, 1'b1);
        applyStimulus(4'd1, ENCRYPT, 128'ha0fafe1788542cb123a339392a6c7605, "keyB_enc1");
        applyStimulus(4'd10, ENCRYPT, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "keyB_enc10");
        applyStimulus(4'd0, ENCRYPT, KEY_B, "keyB_enc0");
        applyStimulus(4'd0, DECRYPT, KEY_B, "keyB_dec0");
        applyStimulus(4'd10, DECRYPT, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "keyB_dec10");
        sweepKeys(1'b0, "sweepB_encFirst");
        sweepKeys(1'b1, "sweepB_decFirst");

        loadKey(128'd0, 4'd3, DECRYPT, decExp(3), "readAtZeroKeyEdge");
        for (int j = 0; j < 4; j++) begin
            applyStimulus(4'(j), ENCRYPT, 128'd0, "readBeforeAbort");
        end
        rst_n = 1'b0;
        pushCheck(K_KREADY, cyc, 128'd0, "abortKeyReady");
        pushCheck(K_KVALID, cyc, 128'd0, "abortKeysValid");
        pushCheck(K_RDKEY, cyc, 128'd0, "abortRdKey");
        tick();
        pushCheck(K_KREADY, cyc, 128'd0, "abortHeldKeyReady");
        tick();
        rst_n = 1'b1;
        pushCheck(K_KREADY, cyc, 128'd0, "abortReleaseKeyReady");
        tick();
        pushCheck(K_KREADY, cyc, 128'd1, "abortAfterClockKeyReady");
        for (int j = 0; j < 15; j++) begin
            pushCheck(K_KVALID, cyc, 128'd0, "keysValidStaysLowAfterAbort");
            applyStimulus(4'(j % 11), ENCRYPT, 128'd0, "readAfterAbort");
        end

        loadKey(128'd0, 4'd0, ENCRYPT, 128'd0, "readAtFreshAccept");
        expandWait(KEY_J, 1'b0);
        applyStimulus(4'd1, ENCRYPT, {4{32'h62636363}}, "zeroKey_enc1");
        sweepKeys(1'b1, "sweepZero");

        tick();
        tick();
        tick();
        while (sbQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL %s: got no comparison, required one due at cycle %0d",
                     sbQ[0].name, sbQ[0].due);
            sbQ.delete(0);
        end
        printSummary();
        $finish;
    end

endmodule
